// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit engines: state encodings,
// default widths and frame-length helper.
package uart_pkg;

    localparam int unsigned KW_DEF   = 19;
    localparam int unsigned KMIN_DEF = 16;
    localparam int unsigned SR_W     = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } rx_state_t;

    // Bits clocked in after the start bit: data (7/8) + optional parity + stop.
    function automatic logic [3:0] frame_len(input logic eight, input logic pen);
        return 4'd8 + {3'b000, eight} + {3'b000, pen};
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-cell timer: latches the bit time K and flags the half-cell
// (H-1) and full-cell (K-1) counts while counting.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned KW = KW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [KW-1:0] k_in,
    input  logic          clr,
    input  logic          en,
    output logic          half_tick,
    output logic          full_tick
);

    logic [KW-1:0] count;
    logic [KW-1:0] k_reg;
    logic [KW-1:0] h_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            k_reg <= '0;
            h_reg <= '0;
        end else begin
            if (load) begin
                k_reg <= k_in;
                h_reg <= k_in >> 1;
            end
            if (clr || load)
                count <= '0;
            else if (en)
                count <= count + KW'(1);
        end
    end

    assign half_tick = (count == h_reg - KW'(1));
    assign full_tick = (count == k_reg - KW'(1));

endmodule

// File: rtl/uart_rx_engine.sv
// UART serial receive engine: synchronises rx, qualifies the start bit at mid-cell,
// shifts in 7/8 data bits with optional parity and reports ready plus sticky error flags.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int unsigned KW   = KW_DEF,
    parameter int unsigned KMIN = KMIN_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    input  logic [KW-1:0] baud_k,
    input  logic          eight,
    input  logic          pen,
    input  logic          ohel,
    input  logic          clr_rdy,
    output logic [7:0]    rx_data,
    output logic          rxrdy,
    output logic          perr,
    output logic          ferr,
    output logic          ovf
);

    rx_state_t       state, state_nxt;
    logic            rx_m, rx_s, rx_p;
    logic            start_edge;
    logic [3:0]      cnt, cnt_nxt;
    logic [SR_W-1:0] sr, sr_nxt;
    logic            eight_l, pen_l, ohel_l;
    logic            latch_cfg;
    logic [3:0]      t_len;
    logic [KW-1:0]   k_eff;
    logic            t_load, t_clr, t_en;
    logic            half_tick, full_tick;
    logic [SR_W-1:0] a;
    logic [7:0]      d;
    logic            p_bit, stop_bit, par_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    assign start_edge = rx_p & ~rx_s;
    assign k_eff      = (baud_k < KW'(KMIN)) ? KW'(KMIN) : baud_k;
    assign t_len      = frame_len(eight_l, pen_l);

    uart_bit_timer #(.KW(KW)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (t_load),
        .k_in      (k_eff),
        .clr       (t_clr),
        .en        (t_en),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            sr      <= '1;
            eight_l <= 1'b0;
            pen_l   <= 1'b0;
            ohel_l  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sr    <= sr_nxt;
            if (latch_cfg) begin
                eight_l <= eight;
                pen_l   <= pen;
                ohel_l  <= ohel;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        t_load    = 1'b0;
        t_clr     = 1'b0;
        t_en      = 1'b0;
        latch_cfg = 1'b0;
        unique case (state)
            IDLE: begin
                t_clr   = 1'b1;
                cnt_nxt = '0;
                if (start_edge) begin
                    t_load    = 1'b1;
                    latch_cfg = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                // A start bit that has gone high again by mid-cell is a glitch.
                if (half_tick) begin
                    t_clr     = 1'b1;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    t_en = 1'b1;
                end
            end
            DATA: begin
                if (full_tick) begin
                    t_clr   = 1'b1;
                    sr_nxt  = {rx_s, sr[SR_W-1:1]};
                    cnt_nxt = cnt + 4'd1;
                    if (cnt + 4'd1 == t_len)
                        state_nxt = DONE;
                end else begin
                    t_en = 1'b1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Right-align the frame so bit 0 is the first data bit regardless of length.
    always_comb begin
        a        = sr >> (4'(SR_W) - t_len);
        d        = eight_l ? a[7:0] : {1'b0, a[6:0]};
        p_bit    = a[4'd7 + {3'b000, eight_l}];
        stop_bit = a[t_len - 4'd1];
        par_bad  = pen_l & ((^d ^ p_bit) != ohel_l);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data <= '0;
            rxrdy   <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            ovf     <= 1'b0;
        end else if (state == DONE) begin
            // A coincident clr_rdy clears the old flags but the new frame still lands.
            rx_data <= d;
            rxrdy   <= 1'b1;
            ferr    <= (ferr & ~clr_rdy) | ~stop_bit;
            perr    <= (perr & ~clr_rdy) | par_bad;
            ovf     <= (ovf & ~clr_rdy) | (rxrdy & ~clr_rdy);
        end else if (clr_rdy) begin
            rxrdy <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            ovf   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: directed frames plus randomized frames
// checked against a frame-level reference model.
module tb_uart_rx_engine;

    localparam int KW   = 19;
    localparam int KMIN = 16;

    logic          clk;
    logic          reset;
    logic          rx;
    logic [KW-1:0] baud_k;
    logic          eight;
    logic          pen;
    logic          ohel;
    logic          clr_rdy;
    logic [7:0]    rx_data;
    logic          rxrdy;
    logic          perr;
    logic          ferr;
    logic          ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_data;
    logic       m_rdy, m_perr, m_ferr, m_ovf;

    uart_rx_engine #(.KW(KW), .KMIN(KMIN)) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .baud_k  (baud_k),
        .eight   (eight),
        .pen     (pen),
        .ohel    (ohel),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rxrdy   (rxrdy),
        .perr    (perr),
        .ferr    (ferr),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".rx_data"}, 32'(rx_data), 32'(m_data));
        check_val({tag, ".rxrdy"},   32'(rxrdy),   32'(m_rdy));
        check_val({tag, ".perr"},    32'(perr),    32'(m_perr));
        check_val({tag, ".ferr"},    32'(ferr),    32'(m_ferr));
        check_val({tag, ".ovf"},     32'(ovf),     32'(m_ovf));
    endtask

    task automatic model_reset();
        m_data = '0;
        m_rdy  = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] data, input logic e, input logic p_en,
                               input logic odd, input logic pbit, input logic sbit,
                               input bit clr_done);
        logic [7:0] dv;
        int         ones;
        dv   = e ? data : {1'b0, data[6:0]};
        ones = $countones(dv) + int'(pbit);
        if (clr_done) begin
            m_perr = 1'b0;
            m_ferr = 1'b0;
            m_ovf  = 1'b0;
        end
        m_ovf  = m_ovf | (m_rdy & !clr_done);
        m_ferr = m_ferr | !sbit;
        m_perr = m_perr | (p_en && ((ones % 2) != int'(odd)));
        m_rdy  = 1'b1;
        m_data = dv;
    endtask

    task automatic clear_flags();
        @(negedge clk) clr_rdy = 1'b1;
        @(negedge clk) clr_rdy = 1'b0;
        m_rdy  = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // Drives one frame at K clocks per cell; clr_at is the clock index (from the
    // falling start edge) at which clr_rdy pulses, -1 for none.
    task automatic send_frame(input logic [7:0] data, input logic e, input logic p_en,
                              input logic odd, input logic pbit, input logic sbit,
                              input int baud, input int clr_at, input bit scramble,
                              input logic after_lvl);
        int          k, h, t, idx;
        logic [10:0] cells;
        k = (baud < KMIN) ? KMIN : baud;
        h = k / 2;
        t = 8 + int'(e) + int'(p_en);
        baud_k = KW'(baud);
        eight  = e;
        pen    = p_en;
        ohel   = odd;
        cells    = '1;
        cells[0] = 1'b0;
        for (int i = 0; i < 7 + int'(e); i++) cells[i + 1] = data[i];
        idx = 8 + int'(e);
        if (p_en) begin
            cells[idx] = pbit;
            idx++;
        end
        cells[idx] = sbit;
        for (int c = 0; c < (t + 1) * k; c++) begin
            @(negedge clk);
            rx      = cells[c / k];
            clr_rdy = (c == clr_at);
            if (scramble && c == 2 * k) begin
                baud_k = KW'($urandom_range(4, 40));
                eight  = 1'($urandom);
                pen    = 1'($urandom);
                ohel   = 1'($urandom);
            end
        end
        @(negedge clk);
        rx      = after_lvl;
        clr_rdy = 1'b0;
        repeat (4) @(negedge clk);
        model_frame(data, e, p_en, odd, pbit, sbit, clr_at == 3 + h + t * k);
    endtask

    initial begin
        int       done_idx;
        int       baud;
        logic [7:0] data;
        logic     e, p_en, odd, pbit, sbit;

        reset   = 1'b1;
        rx      = 1'b1;
        clr_rdy = 1'b0;
        eight   = 1'b1;
        pen     = 1'b0;
        ohel    = 1'b0;
        baud_k  = KW'(16);
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        send_frame(8'h41, 1, 0, 0, 0, 1, 16, -1, 0, 1'b1);
        check_outputs("8n1_41");
        clear_flags();
        check_outputs("clr_keeps_data");

        send_frame(8'h53, 0, 1, 0, 0, 1, 16, -1, 0, 1'b1);
        check_outputs("7e1_good");
        send_frame(8'h53, 0, 1, 0, 1, 1, 16, -1, 0, 1'b1);
        check_outputs("7e1_bad");
        clear_flags();

        send_frame(8'hA5, 1, 1, 1, 1, 0, 16, -1, 0, 1'b1);
        check_outputs("8o1_stop0");
        clear_flags();

        send_frame(8'h11, 1, 0, 0, 0, 1, 16, -1, 0, 1'b1);
        send_frame(8'h22, 1, 0, 0, 0, 1, 16, -1, 0, 1'b1);
        check_outputs("overrun");
        clear_flags();

        done_idx = 3 + 8 + 9 * 16;
        send_frame(8'h11, 1, 0, 0, 0, 1, 16, -1, 0, 1'b1);
        send_frame(8'h22, 1, 0, 0, 0, 1, 16, done_idx, 0, 1'b1);
        check_outputs("clr_on_done");
        clear_flags();

        baud_k = KW'(16);
        @(negedge clk) rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check_outputs("glitch_k16");

        baud_k = KW'(4);
        @(negedge clk) rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check_outputs("glitch_k4");

        send_frame(8'h3C, 1, 0, 0, 0, 1, 4, -1, 0, 1'b1);
        check_outputs("k4_as_k16");
        clear_flags();

        send_frame(8'h00, 1, 0, 0, 0, 0, 16, -1, 0, 1'b0);
        repeat (12 * 16) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check_outputs("break");

        baud_k = KW'(16);
        eight  = 1'b1;
        pen    = 1'b0;
        for (int c = 0; c < 5 * 16; c++) begin
            @(negedge clk);
            rx = (c < 16) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        model_reset();
        #1 check_outputs("reset_mid_frame");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(8'h0F, 1, 0, 0, 0, 1, 16, -1, 0, 1'b1);
        check_outputs("after_reset");

        for (int n = 0; n < 24; n++) begin
            data = 8'($urandom);
            e    = 1'($urandom);
            p_en = 1'($urandom);
            odd  = 1'($urandom);
            pbit = 1'($urandom);
            sbit = ($urandom_range(0, 3) != 0);
            baud = int'($urandom_range(4, 40));
            if ($urandom_range(0, 2) == 0) clear_flags();
            if ($urandom_range(0, 3) == 0)
                done_idx = 3 + (((baud < KMIN) ? KMIN : baud) / 2)
                           + (8 + int'(e) + int'(p_en)) * ((baud < KMIN) ? KMIN : baud);
            else
                done_idx = -1;
            send_frame(data, e, p_en, odd, pbit, sbit, baud, done_idx, 1, 1'b1);
            check_outputs($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
Serial receive engine for the UART peripheral.
- Synchronises the asynchronous Rx pin and locates the start bit, then samples each bit at mid-cell.
- Assembles 7- or 8-bit characters, with optional parity.
- Presents the character, a ready flag and error flags to the UART port-read logic, which feeds the TramelBlaze IN_PORT mux and interrupt.
- The port read strobe (read decode of the status/data port) clears the flags.

Parameters:
KW, 19, width of the bit-time count input and the internal bit timer.
KMIN, 16, minimum effective bit time in clocks. Any smaller baud_k is treated as KMIN.

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high (from the synchronised reset); clock clk
rx  in  1  serial line, asynchronous, idle high
baud_k  in  KW  clocks per bit, from the baud decode of the switches; sampled only in IDLE
eight  in  1  1 = 8 data bits, 0 = 7 data bits; sampled at start detect
pen  in  1  parity enable; sampled at start detect
ohel  in  1  1 = odd parity, 0 = even; sampled at start detect
clr_rdy  in  1  one-cycle pulse from the data-port read strobe
rx_data  out  8  last received character; bit 7 = 0 in 7-bit mode
rxrdy  out  1  character available
perr  out  1  parity error (sticky)
ferr  out  1  framing error (sticky)
ovf  out  1  overrun error (sticky)

Behaviour:
- Reset: all outputs 0, state IDLE, timer 0, bit count 0, shift register 10'h3FF, sync flops 1.
- Sync: rx passes through 2 flip-flops to give rx_s (2-cycle latency); rx_p is the previous rx_s.
- Effective bit time: K = max(baud_k, KMIN). H = K >> 1.
- Frame bit count after start: T = 7 + eight + pen + 1 (stop). Range 8..10.
- States (2-bit, encodings in package):
  - IDLE: timer = 0, cnt = 0. On rx_p=1 & rx_s=0, latch K, H, eight, pen, ohel and go to START.
  - START: timer increments. When timer == H-1, timer is cleared. If rx_s=1 this is a false start: go to IDLE, no flags change. Otherwise go to DATA.
  - DATA: timer increments. When timer == K-1, timer is cleared, sr <= {rx_s, sr[9:1]} (LSB first) and cnt++. When cnt reaches T, go to DONE.
  - DONE: lasts one cycle.
    - a = sr >> (10-T).
    - d = eight ? a[7:0] : {1'b0, a[6:0]}.
    - p = a[7+eight].
    - stop = a[T-1].
    - rx_data <= d; rxrdy <= 1.
    - ferr <= ferr | ~stop.
    - perr <= perr | (pen & ((^d ^ p) != ohel)).
    - ovf <= ovf | (rxrdy & ~clr_rdy).
    - Then go to IDLE.
- Latency: rxrdy rises 2 + H + T*K + 1 clocks after the rx falling edge (±1 for sync alignment).
- clr_rdy: clears rxrdy, perr, ferr and ovf next edge. If it coincides with DONE, the DONE updates win: rxrdy = 1; flags take their DONE-computed values with old values treated as cleared.
- rx_data holds until the next DONE. It is not cleared by clr_rdy.
- Line held low (break): frame completes with ferr=1 and d=0. No new start until rx_s returns high, because edge detection is required.
- rx glitch shorter than H clocks: rejected as a false start.
- Async reset mid-frame: immediate return to IDLE, partial character discarded, flags 0.
- baud_k changes mid-frame: ignored until the next IDLE.

Decomposition:
- Package uart_pkg holds:
  - state encodings IDLE/START/DATA/DONE
  - KW and KMIN defaults
  - SR_W = 10
  - function frame_len(eight, pen)
- Sub-module uart_bit_timer: loadable KW-bit counter with clear, producing half_tick (== H-1) and full_tick (== K-1). It is shared later with the transmit engine.
- The synchroniser is inline.

Test Plan:
- baud_k=16, 8N1, send 0x41 -> after the frame, rx_data=0x41 and rxrdy=1, with perr=ferr=ovf=0. clr_rdy pulse -> rxrdy=0 and rx_data still 0x41.
- baud_k=16, 7E1 (eight=0, pen=1, ohel=0), send 0x53 with parity 0, then with parity 1 -> first: rx_data=0x53, perr=0. Second: perr=1.
- 8O1 send 0xA5 with a correct odd parity bit 1 but stop bit 0 -> rx_data=0xA5, perr=0, ferr=1.
- Two 8N1 frames 0x11 then 0x22 with no clr_rdy between -> rx_data=0x22, ovf=1. Repeat with clr_rdy on the exact DONE cycle of frame 2 -> rxrdy=1, ovf=0.
- rx low pulse of 5 clocks (baud_k=16) -> no state advance past START, rxrdy stays 0. baud_k=4 -> behaves as 16.
- Assert reset at bit 4 of a 0xFF frame, release, send 0x0F -> all outputs 0 during reset; next rx_data=0x0F with no errors.
